control_unit: RTL and testbench

- Hardwired Moore control sequencer that drives every control input of Datapath, replacing the hand-sequenced T-step stimulus used in the datapath benches.
- Fetches the instruction, decodes the opcode in IR[31:27], and steps through T0..T7 asserting the per-step control signal groups.
- It sits directly upstream of Datapath. It consumes Datapath's IR contents and ConFFQ, and produces all of Datapath's enables and ALU selects.

---
 rtl/control_unit_pkg.sv | 95 +++++++++
 rtl/control_unit_if.sv | 38 +++
 rtl/control_unit_alu_sel.sv | 29 ++
 rtl/control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_control_unit.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// Shared types for the hardwired control sequencer: opcodes, FSM states,
// ALU select indices and the registered control word.
package cu_pkg;

  localparam int OP_W = 5;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_LD   = 5'b00000;
  localparam op_t OP_LDI  = 5'b00001;
  localparam op_t OP_ST   = 5'b00010;
  localparam op_t OP_ADD  = 5'b00011;
  localparam op_t OP_SUB  = 5'b00100;
  localparam op_t OP_AND  = 5'b00101;
  localparam op_t OP_OR   = 5'b00110;
  localparam op_t OP_ROR  = 5'b00111;
  localparam op_t OP_ROL  = 5'b01000;
  localparam op_t OP_SHR  = 5'b01001;
  localparam op_t OP_SHRA = 5'b01010;
  localparam op_t OP_SHL  = 5'b01011;
  localparam op_t OP_ADDI = 5'b01100;
  localparam op_t OP_ANDI = 5'b01101;
  localparam op_t OP_ORI  = 5'b01110;
  localparam op_t OP_DIV  = 5'b01111;
  localparam op_t OP_MUL  = 5'b10000;
  localparam op_t OP_NEG  = 5'b10001;
  localparam op_t OP_NOT  = 5'b10010;
  localparam op_t OP_BR   = 5'b10011;
  localparam op_t OP_JR   = 5'b10100;
  localparam op_t OP_JAL  = 5'b10101;
  localparam op_t OP_IN   = 5'b10110;
  localparam op_t OP_OUT  = 5'b10111;
  localparam op_t OP_MFHI = 5'b11000;
  localparam op_t OP_MFLO = 5'b11001;
  localparam op_t OP_NOP  = 5'b11010;
  localparam op_t OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam int ALU_W    = 13;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_MUL  = 2;
  localparam int ALU_DIV  = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  typedef logic [ALU_W-1:0] alu_sel_t;
  localparam alu_sel_t SEL_ADD = alu_sel_t'(1 << ALU_ADD);

  typedef struct packed {
    logic     hi_in, lo_in, hi_out, lo_out;
    logic     zhigh_in, zlow_in, zhigh_out, zlow_out;
    logic     pc_in, pc_out, inc_pc;
    logic     mdr_in, mdr_out, mar_in, md_mux_read, ir_in, y_in, cse_out;
    logic     inport_out, outport_in;
    alu_sel_t alu;
    logic     gra, grb, grc, r_in, r_out, ba_out;
    logic     ram_read, ram_write, con_in;
  } ctrl_t;

  function automatic logic is_rtype(op_t op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

  function automatic logic is_imm(op_t op);
    return (op >= OP_ADDI) && (op <= OP_ORI);
  endfunction

  function automatic logic is_muldiv(op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_negnot(op_t op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Final execute step of each instruction; halt is handled separately in T3.
  function automatic state_t last_step(op_t op);
    if (is_rtype(op) || is_imm(op) || op == OP_LDI) return S_T5;
    if (op == OP_LD || op == OP_ST)                 return S_T7;
    if (is_muldiv(op) || op == OP_BR)               return S_T6;
    if (is_negnot(op) || op == OP_JAL)              return S_T4;
    return S_T3;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle. CU_MEM_WAIT_EN adds the MemReady handshake.
interface control_unit_if;
  logic [31:0] IR;
  logic ConFFQ, Stop, Run;
  logic HIin, LOin, HIout, LOout, Zhighin, Zlowin, Zhighout, Zlowout;
  logic PCin, PCout, IncPC, MDRin, MDRout, MARin, MDMuxread, IRin, Yin, CSEout;
  logic InPortout, OutPortin;
  logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic RAMread, RAMwrite, CONin;
`ifdef CU_MEM_WAIT_EN
  logic MemReady;
`endif

  modport master (
`ifdef CU_MEM_WAIT_EN
    input  MemReady,
`endif
    input  IR, ConFFQ, Stop,
    output Run, HIin, LOin, HIout, LOout, Zhighin, Zlowin, Zhighout, Zlowout,
    output PCin, PCout, IncPC, MDRin, MDRout, MARin, MDMuxread, IRin, Yin, CSEout,
    output InPortout, OutPortin,
    output ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    output Gra, Grb, Grc, Rin, Rout, BAout, RAMread, RAMwrite, CONin
  );

  modport slave (
`ifdef CU_MEM_WAIT_EN
    output MemReady,
`endif
    output IR, ConFFQ, Stop,
    input  Run, HIin, LOin, HIout, LOout, Zhighin, Zlowin, Zhighout, Zlowout,
    input  PCin, PCout, IncPC, MDRin, MDRout, MARin, MDMuxread, IRin, Yin, CSEout,
    input  InPortout, OutPortin,
    input  ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    input  Gra, Grb, Grc, Rin, Rout, BAout, RAMread, RAMwrite, CONin
  );
endinterface

// File: rtl/control_unit_alu_sel.sv
// Opcode to one-hot ALU select for the R-type, immediate, mul/div and neg/not groups.
module cu_alu_sel
  import cu_pkg::*;
(
  input  op_t      opcode,
  output alu_sel_t sel
);

  always_comb begin
    sel = '0;
    case (opcode)
      OP_ADD, OP_ADDI: sel[ALU_ADD]  = 1'b1;
      OP_SUB:          sel[ALU_SUB]  = 1'b1;
      OP_AND, OP_ANDI: sel[ALU_AND]  = 1'b1;
      OP_OR,  OP_ORI:  sel[ALU_OR]   = 1'b1;
      OP_ROR:          sel[ALU_ROR]  = 1'b1;
      OP_ROL:          sel[ALU_ROL]  = 1'b1;
      OP_SHR:          sel[ALU_SHR]  = 1'b1;
      OP_SHRA:         sel[ALU_SHRA] = 1'b1;
      OP_SHL:          sel[ALU_SHL]  = 1'b1;
      OP_MUL:          sel[ALU_MUL]  = 1'b1;
      OP_DIV:          sel[ALU_DIV]  = 1'b1;
      OP_NEG:          sel[ALU_NEG]  = 1'b1;
      OP_NOT:          sel[ALU_NOT]  = 1'b1;
      default:         ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for Datapath (falling-edge state register).
// Optional CU_MEM_WAIT_EN: T1, ld-T6 and st-T7 stretch until MemReady.
module control_unit
  import cu_pkg::*;
#(
  parameter int OPW = OP_W
) (
  input logic            clock,
  input logic            clear,
  control_unit_if.master cu
);

  state_t   state, nxt;
  ctrl_t    ctrl, nxt_ctrl;
  logic     run;
  op_t      opcode;
  alu_sel_t op_sel;
  logic     mem_ready, hold;

  assign opcode = cu.IR[31 -: OPW];

`ifdef CU_MEM_WAIT_EN
  assign mem_ready = cu.MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  cu_alu_sel u_alu_sel (
    .opcode (opcode),
    .sel    (op_sel)
  );

  assign hold = !mem_ready &&
                ((state == S_T1) ||
                 (state == S_T6 && opcode == OP_LD) ||
                 (state == S_T7 && opcode == OP_ST));

  always_comb begin
    nxt = state;
    if (!hold) begin
      case (state)
        S_RESET: nxt = S_T0;
        S_T0:    nxt = S_T1;
        S_T1:    nxt = S_T2;
        S_T2:    nxt = S_T3;
        S_HALT:  nxt = S_HALT;
        default: begin
          if (state == S_T3 && opcode == OP_HALT)
            nxt = S_HALT;
          else if (state == last_step(opcode))
            nxt = cu.Stop ? S_HALT : S_T0;
          else
            nxt = state_t'(state + 4'd1);
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it, so they
  // equal a Moore decode of the current state without combinational glitches.
  always_comb begin
    nxt_ctrl = '0;
    case (nxt)
      S_T0: begin
        nxt_ctrl.pc_out = 1'b1; nxt_ctrl.mar_in = 1'b1;
        nxt_ctrl.inc_pc = 1'b1; nxt_ctrl.zlow_in = 1'b1;
      end
      S_T1: begin
        nxt_ctrl.zlow_out = 1'b1; nxt_ctrl.pc_in = 1'b1; nxt_ctrl.md_mux_read = 1'b1;
        nxt_ctrl.ram_read = 1'b1; nxt_ctrl.mdr_in = 1'b1;
      end
      S_T2: begin
        nxt_ctrl.mdr_out = 1'b1; nxt_ctrl.ir_in = 1'b1;
      end
      S_T3: begin
        if (is_rtype(opcode) || is_imm(opcode)) begin
          nxt_ctrl.grb = 1'b1; nxt_ctrl.r_out = 1'b1; nxt_ctrl.y_in = 1'b1;
        end else if (opcode inside {OP_LD, OP_LDI, OP_ST}) begin
          nxt_ctrl.grb = 1'b1; nxt_ctrl.ba_out = 1'b1; nxt_ctrl.y_in = 1'b1;
        end else if (is_muldiv(opcode)) begin
          nxt_ctrl.gra = 1'b1; nxt_ctrl.r_out = 1'b1; nxt_ctrl.y_in = 1'b1;
        end else if (is_negnot(opcode)) begin
          nxt_ctrl.grb = 1'b1; nxt_ctrl.r_out = 1'b1;
          nxt_ctrl.alu = op_sel; nxt_ctrl.zlow_in = 1'b1;
        end else begin
          case (opcode)
            OP_BR:   begin nxt_ctrl.gra = 1'b1; nxt_ctrl.r_out = 1'b1; nxt_ctrl.con_in = 1'b1; end
            OP_JR:   begin nxt_ctrl.gra = 1'b1; nxt_ctrl.r_out = 1'b1; nxt_ctrl.pc_in = 1'b1; end
            OP_JAL:  begin nxt_ctrl.pc_out = 1'b1; nxt_ctrl.grb = 1'b1; nxt_ctrl.r_in = 1'b1; end
            OP_IN:   begin nxt_ctrl.inport_out = 1'b1; nxt_ctrl.gra = 1'b1; nxt_ctrl.r_in = 1'b1; end
            OP_OUT:  begin nxt_ctrl.gra = 1'b1; nxt_ctrl.r_out = 1'b1; nxt_ctrl.outport_in = 1'b1; end
            OP_MFHI: begin nxt_ctrl.hi_out = 1'b1; nxt_ctrl.gra = 1'b1; nxt_ctrl.r_in = 1'b1; end
            OP_MFLO: begin nxt_ctrl.lo_out = 1'b1; nxt_ctrl.gra = 1'b1; nxt_ctrl.r_in = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_rtype(opcode)) begin
          nxt_ctrl.grc = 1'b1; nxt_ctrl.r_out = 1'b1;
          nxt_ctrl.alu = op_sel; nxt_ctrl.zlow_in = 1'b1;
        end else if (is_imm(opcode)) begin
          nxt_ctrl.cse_out = 1'b1; nxt_ctrl.alu = op_sel; nxt_ctrl.zlow_in = 1'b1;
        end else if (opcode inside {OP_LD, OP_LDI, OP_ST}) begin
          nxt_ctrl.cse_out = 1'b1; nxt_ctrl.alu = SEL_ADD; nxt_ctrl.zlow_in = 1'b1;
        end else if (is_muldiv(opcode)) begin
          nxt_ctrl.grb = 1'b1; nxt_ctrl.r_out = 1'b1; nxt_ctrl.alu = op_sel;
          nxt_ctrl.zlow_in = 1'b1; nxt_ctrl.zhigh_in = 1'b1;
        end else if (is_negnot(opcode)) begin
          nxt_ctrl.zlow_out = 1'b1; nxt_ctrl.gra = 1'b1; nxt_ctrl.r_in = 1'b1;
        end else if (opcode == OP_BR) begin
          nxt_ctrl.pc_out = 1'b1; nxt_ctrl.y_in = 1'b1;
        end else if (opcode == OP_JAL) begin
          nxt_ctrl.gra = 1'b1; nxt_ctrl.r_out = 1'b1; nxt_ctrl.pc_in = 1'b1;
        end
      end
      S_T5: begin
        if (is_rtype(opcode) || is_imm(opcode) || opcode == OP_LDI) begin
          nxt_ctrl.zlow_out = 1'b1; nxt_ctrl.gra = 1'b1; nxt_ctrl.r_in = 1'b1;
        end else if (opcode == OP_LD || opcode == OP_ST) begin
          nxt_ctrl.zlow_out = 1'b1; nxt_ctrl.mar_in = 1'b1;
        end else if (is_muldiv(opcode)) begin
          nxt_ctrl.zlow_out = 1'b1; nxt_ctrl.lo_in = 1'b1;
        end else if (opcode == OP_BR) begin
          nxt_ctrl.cse_out = 1'b1; nxt_ctrl.alu = SEL_ADD; nxt_ctrl.zlow_in = 1'b1;
        end
      end
      S_T6: begin
        if (opcode == OP_LD) begin
          nxt_ctrl.md_mux_read = 1'b1; nxt_ctrl.ram_read = 1'b1; nxt_ctrl.mdr_in = 1'b1;
        end else if (opcode == OP_ST) begin
          nxt_ctrl.gra = 1'b1; nxt_ctrl.r_out = 1'b1; nxt_ctrl.mdr_in = 1'b1;
        end else if (is_muldiv(opcode)) begin
          nxt_ctrl.zhigh_out = 1'b1; nxt_ctrl.hi_in = 1'b1;
        end else if (opcode == OP_BR) begin
          nxt_ctrl.zlow_out = 1'b1; nxt_ctrl.pc_in = cu.ConFFQ;
        end
      end
      S_T7: begin
        if (opcode == OP_LD) begin
          nxt_ctrl.mdr_out = 1'b1; nxt_ctrl.gra = 1'b1; nxt_ctrl.r_in = 1'b1;
        end else if (opcode == OP_ST) begin
          nxt_ctrl.ram_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      state <= S_RESET;
      ctrl  <= '0;
      run   <= 1'b1;
    end else begin
      state <= nxt;
      ctrl  <= nxt_ctrl;
      run   <= (nxt != S_HALT);
    end
  end

  assign cu.Run       = run;
  assign cu.HIin      = ctrl.hi_in;
  assign cu.LOin      = ctrl.lo_in;
  assign cu.HIout     = ctrl.hi_out;
  assign cu.LOout     = ctrl.lo_out;
  assign cu.Zhighin   = ctrl.zhigh_in;
  assign cu.Zlowin    = ctrl.zlow_in;
  assign cu.Zhighout  = ctrl.zhigh_out;
  assign cu.Zlowout   = ctrl.zlow_out;
  assign cu.PCin      = ctrl.pc_in;
  assign cu.PCout     = ctrl.pc_out;
  assign cu.IncPC     = ctrl.inc_pc;
  assign cu.MDRin     = ctrl.mdr_in;
  assign cu.MDRout    = ctrl.mdr_out;
  assign cu.MARin     = ctrl.mar_in;
  assign cu.MDMuxread = ctrl.md_mux_read;
  assign cu.IRin      = ctrl.ir_in;
  assign cu.Yin       = ctrl.y_in;
  assign cu.CSEout    = ctrl.cse_out;
  assign cu.InPortout = ctrl.inport_out;
  assign cu.OutPortin = ctrl.outport_in;
  assign cu.ADD       = ctrl.alu[ALU_ADD];
  assign cu.SUB       = ctrl.alu[ALU_SUB];
  assign cu.MUL       = ctrl.alu[ALU_MUL];
  assign cu.DIV       = ctrl.alu[ALU_DIV];
  assign cu.AND       = ctrl.alu[ALU_AND];
  assign cu.OR        = ctrl.alu[ALU_OR];
  assign cu.SHR       = ctrl.alu[ALU_SHR];
  assign cu.SHRA      = ctrl.alu[ALU_SHRA];
  assign cu.SHL       = ctrl.alu[ALU_SHL];
  assign cu.ROR       = ctrl.alu[ALU_ROR];
  assign cu.ROL       = ctrl.alu[ALU_ROL];
  assign cu.NEG       = ctrl.alu[ALU_NEG];
  assign cu.NOT       = ctrl.alu[ALU_NOT];
  assign cu.Gra       = ctrl.gra;
  assign cu.Grb       = ctrl.grb;
  assign cu.Grc       = ctrl.grc;
  assign cu.Rin       = ctrl.r_in;
  assign cu.Rout      = ctrl.r_out;
  assign cu.BAout     = ctrl.ba_out;
  assign cu.RAMread   = ctrl.ram_read;
  assign cu.RAMwrite  = ctrl.ram_write;
  assign cu.CONin     = ctrl.con_in;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-step control words against hand-built masks.
module tb_control_unit;

  logic clock = 1'b0;
  logic clear;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   inv_bad  = 0;

  control_unit_if bus ();

  control_unit #(.OPW(5)) dut (
    .clock (clock),
    .clear (clear),
    .cu    (bus)
  );

  always #5 clock = ~clock;

  localparam logic [42:0] HIIN = 43'd1 << 0,  LOIN = 43'd1 << 1,  HIOUT = 43'd1 << 2;
  localparam logic [42:0] LOOUT = 43'd1 << 3, ZHIGHIN = 43'd1 << 4, ZLOWIN = 43'd1 << 5;
  localparam logic [42:0] ZHIGHOUT = 43'd1 << 6, ZLOWOUT = 43'd1 << 7, PCIN = 43'd1 << 8;
  localparam logic [42:0] PCOUT = 43'd1 << 9, INCPC = 43'd1 << 10, MDRIN = 43'd1 << 11;
  localparam logic [42:0] MDROUT = 43'd1 << 12, MARIN = 43'd1 << 13, MDMUX = 43'd1 << 14;
  localparam logic [42:0] IRIN = 43'd1 << 15, YIN = 43'd1 << 16, CSEOUT = 43'd1 << 17;
  localparam logic [42:0] SUB = 43'd1 << 21, MUL = 43'd1 << 22, ADD = 43'd1 << 20;
  localparam logic [42:0] OR = 43'd1 << 25, NEG = 43'd1 << 31;
  localparam logic [42:0] GRA = 43'd1 << 33, GRB = 43'd1 << 34, GRC = 43'd1 << 35;
  localparam logic [42:0] RIN = 43'd1 << 36, ROUT = 43'd1 << 37, BAOUT = 43'd1 << 38;
  localparam logic [42:0] RAMREAD = 43'd1 << 39, RAMWRITE = 43'd1 << 40, CONIN = 43'd1 << 41;
  localparam logic [42:0] RUN = 43'd1 << 42;

  localparam logic [42:0] F0 = RUN | PCOUT | MARIN | INCPC | ZLOWIN;
  localparam logic [42:0] F1 = RUN | ZLOWOUT | PCIN | MDMUX | RAMREAD | MDRIN;
  localparam logic [42:0] F2 = RUN | MDROUT | IRIN;

  typedef logic [42:0] steps_t [8];

  function automatic logic [42:0] obs();
    return {bus.Run, bus.CONin, bus.RAMwrite, bus.RAMread, bus.BAout, bus.Rout, bus.Rin,
            bus.Grc, bus.Grb, bus.Gra, bus.NOT, bus.NEG, bus.ROL, bus.ROR, bus.SHL, bus.SHRA,
            bus.SHR, bus.OR, bus.AND, bus.DIV, bus.MUL, bus.SUB, bus.ADD, bus.OutPortin,
            bus.InPortout, bus.CSEout, bus.Yin, bus.IRin, bus.MDMuxread, bus.MARin, bus.MDRout,
            bus.MDRin, bus.IncPC, bus.PCout, bus.PCin, bus.Zlowout, bus.Zhighout, bus.Zlowin,
            bus.Zhighin, bus.LOout, bus.HIout, bus.LOin, bus.HIin};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // IR is loaded mid-fetch, after T1, as the datapath would do at T2.
  task automatic exec(input string tag, input logic [31:0] instr, input steps_t ex,
                      input int unsigned n, input logic stop);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock); #1;
      check($sformatf("%s_t%0d", tag, i), 64'(obs()), 64'(ex[i]));
      if (i == 1) begin
        bus.IR   = instr;
        bus.Stop = stop;
      end
    end
  endtask

  task automatic halted_for(input string tag, input int unsigned cycles);
    int unsigned bad = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (obs() != '0) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  always @(posedge clock) begin
    if ($countones({bus.ADD, bus.SUB, bus.MUL, bus.DIV, bus.AND, bus.OR, bus.SHR, bus.SHRA,
                    bus.SHL, bus.ROR, bus.ROL, bus.NEG, bus.NOT}) > 1 ||
        (bus.RAMread && bus.RAMwrite))
      inv_bad++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    steps_t s;
    clear    = 1'b0;
    bus.IR   = '0;
    bus.ConFFQ = 1'b0;
    bus.Stop = 1'b0;
`ifdef CU_MEM_WAIT_EN
    bus.MemReady = 1'b1;
`endif
    #1 clear = 1'b1;
    #2 check("reset_async", 64'(obs()), 64'(RUN));
    @(negedge clock); @(posedge clock); #1;
    check("reset_hold", 64'(obs()), 64'(RUN));
    clear = 1'b0;

    s = '{F0, F1, F2, RUN|GRB|ROUT|YIN, RUN|CSEOUT|OR|ZLOWIN, RUN|ZLOWOUT|GRA|RIN, '0, '0};
    exec("ori", {5'b01110, 4'd3, 4'd4, 19'h53}, s, 6, 1'b0);

    s = '{F0, F1, F2, RUN|GRB|BAOUT|YIN, RUN|CSEOUT|ADD|ZLOWIN, RUN|ZLOWOUT|MARIN,
          RUN|MDMUX|RAMREAD|MDRIN, RUN|MDROUT|GRA|RIN};
    exec("ld", {5'b00000, 4'd1, 4'd0, 19'h65}, s, 8, 1'b0);

    bus.ConFFQ = 1'b1;
    s = '{F0, F1, F2, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN, RUN|CSEOUT|ADD|ZLOWIN,
          RUN|ZLOWOUT|PCIN, '0};
    exec("br_taken", {5'b10011, 4'd2, 4'd0, 19'd5}, s, 7, 1'b0);

    bus.ConFFQ = 1'b0;
    s[6] = RUN | ZLOWOUT;
    exec("br_not", {5'b10011, 4'd2, 4'd0, 19'd5}, s, 7, 1'b0);

    s = '{F0, F1, F2, RUN|GRA|ROUT|YIN, RUN|GRB|ROUT|MUL|ZLOWIN|ZHIGHIN, RUN|ZLOWOUT|LOIN,
          RUN|ZHIGHOUT|HIIN, '0};
    exec("mul", {5'b10000, 4'd3, 4'd1, 19'd0}, s, 7, 1'b0);

    s = '{F0, F1, F2, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|SUB|ZLOWIN, RUN|ZLOWOUT|GRA|RIN, '0, '0};
    exec("sub", {5'b00100, 4'd5, 4'd6, 4'd7, 15'd0}, s, 6, 1'b0);

    s = '{F0, F1, F2, RUN|GRB|ROUT|NEG|ZLOWIN, RUN|ZLOWOUT|GRA|RIN, '0, '0, '0};
    exec("neg", {5'b10001, 4'd2, 4'd3, 19'd0}, s, 5, 1'b0);

    s = '{F0, F1, F2, RUN|PCOUT|GRB|RIN, RUN|GRA|ROUT|PCIN, '0, '0, '0};
    exec("jal", {5'b10101, 4'd4, 4'd15, 19'd0}, s, 5, 1'b0);

    s = '{F0, F1, F2, RUN|HIOUT|GRA|RIN, '0, '0, '0, '0};
    exec("mfhi", {5'b11000, 4'd6, 23'd0}, s, 4, 1'b0);

    s = '{F0, F1, F2, RUN, '0, '0, '0, '0};
    exec("undef", {5'b11110, 27'd0}, s, 4, 1'b0);

    // st aborted by clear in T6; the next T0 sample shows the restart.
    s = '{F0, F1, F2, RUN|GRB|BAOUT|YIN, RUN|CSEOUT|ADD|ZLOWIN, RUN|ZLOWOUT|MARIN,
          RUN|GRA|ROUT|MDRIN, RUN|RAMWRITE};
    exec("st_abort", {5'b00010, 4'd3, 4'd0, 19'h20}, s, 7, 1'b0);
    clear = 1'b1;
    #1 check("clear_mid_st", 64'(obs()), 64'(RUN));
    #1 clear = 1'b0;
    exec("st_full", {5'b00010, 4'd3, 4'd0, 19'h20}, s, 8, 1'b0);

    s = '{F0, F1, F2, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ADD|ZLOWIN, RUN|ZLOWOUT|GRA|RIN, '0, '0};
    exec("add_stop", {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, s, 6, 1'b1);
    halted_for("stop_halt", 20);
    bus.Stop = 1'b0;
    clear = 1'b1;
    #1 check("clear_from_halt", 64'(obs()), 64'(RUN));
    #1 clear = 1'b0;

    s = '{F0, F1, F2, RUN, '0, '0, '0, '0};
    exec("halt", {5'b11011, 27'd0}, s, 4, 1'b0);
    halted_for("halt_instr", 20);

    check("invariants", 64'(inv_bad), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
